// File: rtl/time_set_ctrl_pkg.sv
// Shared types, field codes and BCD limits for the time/alarm setting controller.
// Also holds the BCD increment helpers used by the edit datapath.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EDIT_HR  = 2'b01,
    EDIT_MIN = 2'b10,
    COMMIT   = 2'b11
  } state_t;

  typedef enum logic {
    TGT_TIME  = 1'b0,
    TGT_ALARM = 1'b1
  } target_t;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;
  localparam logic [1:0] FIELD_COMMIT  = 2'b11;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  function automatic hhmm_t inc_hours(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.h1 == 2'(HR_MAX / 10) && v.h0 == 4'(HR_MAX % 10)) begin
      r.h1 = '0;
      r.h0 = '0;
    end else if (v.h0 == 4'd9) begin
      r.h1 = v.h1 + 2'd1;
      r.h0 = '0;
    end else begin
      r.h0 = v.h0 + 4'd1;
    end
    return r;
  endfunction

  // Minutes wrap on their own and never carry into the hours digits.
  function automatic hhmm_t inc_minutes(input hhmm_t v);
    hhmm_t r;
    r = v;
    if (v.m0 == 4'd9) begin
      r.m0 = '0;
      r.m1 = (v.m1 == 3'(MIN_MAX / 10)) ? 3'd0 : v.m1 + 3'd1;
    end else begin
      r.m0 = v.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, stable-count debounce and a one-cycle
// press pulse on the accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  // A button held across reset release must first be seen released for this
  // many samples (synchronizer latency included) before presses are honoured.
  localparam int ARM_CYCLES = DB_CYCLES + 2;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] arm_cnt_q, arm_cnt_d;
  logic          press_q, press_d;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    level_d   = level_q;
    cnt_d     = '0;
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;

    if (sync_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) level_d = sync_q;
      else                             cnt_d   = cnt_q + 1'b1;
    end

    if (!armed_q) begin
      if (sync_q)                                  arm_cnt_d = '0;
      else if (arm_cnt_q == CW'(ARM_CYCLES - 1))   armed_d   = 1'b1;
      else                                         arm_cnt_d = arm_cnt_q + 1'b1;
    end

    press_d = armed_q & ~level_q & level_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, including the synchronizer pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      meta_q    <= btn_i;
      sync_q    <= meta_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      arm_cnt_q <= arm_cnt_d;
      press_q   <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Three-button HH:MM editor that loads either the running clock or the alarm
// through a shared BCD load bus with held load strobes.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int LD_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       busy,
  output logic [1:0] field
);

  localparam int LW = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;

  logic ev_mode, ev_set, ev_inc;

  state_t        state_q, state_d;
  target_t       target_q, target_d;
  hhmm_t         value_q, value_d;
  logic [LW-1:0] ld_cnt_q, ld_cnt_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(reset), .btn_i(btn_mode), .press_o(ev_mode)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk(clk), .rst_n(reset), .btn_i(btn_set), .press_o(ev_set)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(reset), .btn_i(btn_inc), .press_o(ev_inc)
  );

  // The if/else ladders encode set > mode > inc; losers in a cycle are dropped.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    value_d  = value_q;
    ld_cnt_d = ld_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (ev_set) begin
          state_d  = EDIT_HR;
          target_d = TGT_ALARM;
        end else if (ev_mode) begin
          state_d  = EDIT_HR;
          target_d = TGT_TIME;
        end
      end
      EDIT_HR: begin
        if      (ev_set)  state_d = IDLE;
        else if (ev_mode) state_d = EDIT_MIN;
        else if (ev_inc)  value_d = inc_hours(value_q);
      end
      EDIT_MIN: begin
        if (ev_set) begin
          state_d = IDLE;
        end else if (ev_mode) begin
          state_d  = COMMIT;
          ld_cnt_d = '0;
        end else if (ev_inc) begin
          value_d = inc_minutes(value_q);
        end
      end
      COMMIT: begin
        if (ld_cnt_q == LW'(LD_HOLD - 1)) begin
          state_d  = IDLE;
          ld_cnt_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      target_q <= TGT_TIME;
      value_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      value_q  <= value_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Strobes decode straight from registered state so the async reset kills
  // them immediately.
  always_comb begin
    busy     = (state_q != IDLE);
    LD_time  = (state_q == COMMIT) && (target_q == TGT_TIME);
    LD_alarm = (state_q == COMMIT) && (target_q == TGT_ALARM);
    unique case (state_q)
      EDIT_HR:  field = FIELD_HOURS;
      EDIT_MIN: field = FIELD_MINUTES;
      COMMIT:   field = FIELD_COMMIT;
      default:  field = FIELD_NONE;
    endcase
  end

  assign H_in1 = value_q.h1;
  assign H_in0 = value_q.h0;
  assign M_in1 = value_q.m1;
  assign M_in0 = value_q.m0;

  a_strobes_exclusive : assert property (
    @(posedge clk) disable iff (!reset) !(LD_time && LD_alarm)
  );

  a_value_stable_in_commit : assert property (
    @(posedge clk) disable iff (!reset) (state_q == COMMIT) |=> $stable(value_q)
  );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: stimulus queues expected value changes
// and load events; a negedge monitor pops and compares as the DUT shows them.
module tb_time_set_ctrl;

  localparam int DB  = 4;
  localparam int LDH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_set, btn_inc;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [2:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time, LD_alarm, busy;
  logic [1:0] field;

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_val_q[$];
  logic [13:0] exp_ld_q[$];

  time_set_ctrl #(.DB_CYCLES(DB), .LD_HOLD(LDH)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .busy(busy), .field(field)
  );

  always #5 clk = ~clk;

  wire [12:0] dut_val = {H_in1, H_in0, M_in1, M_in0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1; else if (which == 1) btn_set = 1'b1; else btn_inc = 1'b1;
    cycles(12);
    btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
    cycles(12);
  endtask

  task automatic inc_expect(input logic [12:0] v);
    exp_val_q.push_back(v);
    press(2);
  endtask

  // Monitor: value changes and strobe windows are matched against the queues.
  logic [12:0] prev_val = '0;
  logic        in_ld    = 1'b0;
  int          ld_len   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_val = '0;
      in_ld    = 1'b0;
      ld_len   = 0;
    end else begin
      if (dut_val !== prev_val) begin
        if (exp_val_q.size() == 0) check("unexpected_value_change", dut_val, prev_val);
        else                       check("value", dut_val, exp_val_q.pop_front());
        prev_val = dut_val;
      end
      if (LD_time || LD_alarm) begin
        if (!in_ld) begin
          check("strobe_exclusive", {LD_alarm, LD_time} == 2'b11, 0);
          if (exp_ld_q.size() == 0) check("unexpected_load", {LD_alarm, dut_val}, 0);
          else                      check("load_target_value", {LD_alarm, dut_val}, exp_ld_q.pop_front());
          in_ld  = 1'b1;
          ld_len = 1;
        end else begin
          if (LD_time && LD_alarm) check("strobe_exclusive", 1, 0);
          ld_len++;
        end
      end else if (in_ld) begin
        check("load_length", ld_len, LDH);
        in_ld = 1'b0;
      end
    end
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; btn_mode = 1'b0; btn_set = 1'b0; btn_inc = 1'b0;
    cycles(3);
    check("rst_value", dut_val, 0);
    check("rst_strobes", {LD_time, LD_alarm}, 0);
    check("rst_busy", busy, 0);
    check("rst_field", field, 2'b00);
    reset = 1'b1;
    cycles(12);

    // Time load 05:00
    press(0);
    check("field_hours", field, 2'b01);
    check("busy_edit", busy, 1);
    for (int i = 1; i <= 5; i++) inc_expect(mk(i, 0));
    press(0);
    check("field_minutes", field, 2'b10);
    exp_ld_q.push_back({1'b0, mk(5, 0)});
    press(0);
    check("idle_after_time_load", field, 2'b00);

    // Alarm load 05:03
    press(1);
    check("alarm_field_hours", field, 2'b01);
    press(0);
    for (int i = 1; i <= 3; i++) inc_expect(mk(5, i));
    exp_ld_q.push_back({1'b1, mk(5, 3)});
    press(0);
    check("idle_after_alarm_load", busy, 0);

    // Reset during commit, mode held through reset release
    press(0);
    press(0);
    exp_ld_q.push_back({1'b0, mk(5, 3)});
    btn_mode = 1'b1;
    for (int i = 0; i < 40 && !LD_time; i++) @(negedge clk);
    check("abort_commit_reached", LD_time, 1);
    @(posedge clk);
    #1;
    check("abort_strobe_live", LD_time, 1);
    reset = 1'b0;
    #1;
    check("abort_strobe_dropped", {LD_time, LD_alarm}, 0);
    cycles(3);
    reset = 1'b1;
    cycles(20);
    check("post_abort_field", field, 2'b00);
    check("post_abort_value", dut_val, 0);
    btn_mode = 1'b0;
    cycles(20);
    check("held_button_no_event", busy, 0);
    check("held_button_strobes", {LD_time, LD_alarm}, 0);

    // Wraps from 00:00
    press(0);
    for (int i = 1; i <= 24; i++) begin
      inc_expect(mk(i % 24, 0));
      if (i == 23) check("hours_at_23", {H_in1, H_in0}, 6'h23);
    end
    press(0);
    for (int i = 1; i <= 60; i++) begin
      inc_expect(mk(0, i % 60));
      if (i == 59) check("minutes_at_59", {M_in1, M_in0}, 7'h59);
    end
    check("hours_untouched_by_min_wrap", {H_in1, H_in0}, 6'h00);
    press(1);
    check("cancel_to_idle", field, 2'b00);

    // Bounce then a too-short pulse, in EDIT_MIN
    press(0);
    press(0);
    exp_val_q.push_back(mk(0, 1));
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      cycles(1);
    end
    btn_inc = 1'b1;
    cycles(12);
    btn_inc = 1'b0;
    cycles(12);
    btn_inc = 1'b1;
    cycles(DB - 2);
    btn_inc = 1'b0;
    cycles(12);
    check("one_inc_after_bounce", dut_val, mk(0, 1));

    // set + inc together cancels; value retained into next session
    btn_set = 1'b1;
    btn_inc = 1'b1;
    cycles(12);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    cycles(12);
    check("priority_cancel_field", field, 2'b00);
    check("priority_cancel_value", dut_val, mk(0, 1));
    press(0);
    check("retained_field", field, 2'b01);
    check("retained_value", dut_val, mk(0, 1));
    press(0);
    exp_ld_q.push_back({1'b0, mk(0, 1)});
    press(0);
    check("final_idle", field, 2'b00);

    cycles(5);
    check("value_queue_drained", exp_val_q.size(), 0);
    check("load_queue_drained", exp_ld_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
